// File: rtl/cla_seq_adder_if.sv
// Operand/result bundle for the sequenced CLA adder; start/busy/done handshake.
// Latency: none (wires only).
// Backpressure: the source must watch busy_out; starts while busy are dropped.
interface cla_seq_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start_in;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic         C0_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] S_out;
  logic         C_out;
  logic         ovf_out;

  // Operand source / controller side
  modport master (
    output start_in, A_in, B_in, C0_in,
    input  busy_out, done_out, S_out, C_out, ovf_out
  );

  // Adder side
  modport slave (
    input  start_in, A_in, B_in, C0_in,
    output busy_out, done_out, S_out, C_out, ovf_out
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Wide adder built from one registered 4-bit CLA slice, stepped LSB nibble first.
// Latency: NIBBLES+1 cycles from the accepting edge to the done pulse.
// Backpressure: start is sampled only while idle; starts during busy are dropped.
module cla_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  cla_seq_adder_if.slave  bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES + 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]   a_lat_q, a_lat_d;
  logic [W-1:0]   b_lat_q, b_lat_d;
  logic           c0_lat_q, c0_lat_d;
  logic [3:0]     s_q, s_d;
  logic           c_q, c_d;
  logic [W-1:0]   res_q, res_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  // Slice operands and result (combinational part of the single shared slice)
  logic [3:0] a_nib, b_nib, g, p, slice_s;
  logic       slice_cin, c1, c2, c3, c4;

  // Select the current nibble of each latched operand and the slice carry-in
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDXW'(n)) begin
        a_nib = a_lat_q[4*n +: 4];
        b_nib = b_lat_q[4*n +: 4];
      end
    end
    slice_cin = (idx_q == '0) ? c0_lat_q : c_q;
  end

  // 4-bit carry-lookahead: all carries from generate/propagate and the slice carry-in
  always_comb begin
    g  = a_nib & b_nib;
    p  = a_nib ^ b_nib;
    c1 = g[0] | (p[0] & slice_cin);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & slice_cin);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & slice_cin);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & slice_cin);
    slice_s = p ^ {c3, c2, c1, slice_cin};
  end

  // Next-state: accept in IDLE, step one nibble per cycle in RUN, retire at idx==NIBBLES
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    c0_lat_d = c0_lat_q;
    s_d      = s_q;
    c_d      = c_q;
    res_d    = res_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          a_lat_d  = bus.A_in;
          b_lat_d  = bus.B_in;
          c0_lat_d = bus.C0_in;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // The slice output registered last cycle belongs to nibble idx-1
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDXW'(n + 1)) begin
            res_d[4*n +: 4] = s_q;
          end
        end
        if (idx_q != IDX_LAST) begin
          s_d   = slice_s;
          c_d   = c4;
          idx_d = idx_q + IDXW'(1);
        end else begin
          cout_d  = c_q;
          ovf_d   = (a_lat_q[W-1] == b_lat_q[W-1]) && (s_q[3] != a_lat_q[W-1]);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      c0_lat_q <= 1'b0;
      s_q      <= '0;
      c_q      <= 1'b0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      c0_lat_q <= c0_lat_d;
      s_q      <= s_d;
      c_q      <= c_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy_out = (state_q == RUN);
  assign bus.done_out = done_q;
  assign bus.S_out    = res_q;
  assign bus.C_out    = cout_q;
  assign bus.ovf_out  = ovf_q;
endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide adder controller that sequences a single 4-bit registered carry-lookahead slice across NIBBLES nibbles, least-significant first. It chains each slice carry-out into the next slice carry-in. The slice is functionally identical to the team's `full` 4-bit CLA adder: registered S/C4, one-cycle latency. The block owns that slice and exposes a start/busy/done handshake with a W = 4*NIBBLES-bit result. It sits between the operand source and any wider arithmetic consumer, trading latency for a single shared 4-bit adder.

## Interface
- NIBBLES, default 4: number of 4-bit slices per operation, ≥1; W = 4*NIBBLES.
- clk  in  1  rising-edge clock.
- rst  in  1  reset: asynchronous, active-high.
- start_in  in  1  request; sampled only when busy_out=0.
- A_in  in  W  operand A; latched on accepted start.
- B_in  in  W  operand B; latched on accepted start.
- C0_in  in  1  carry-in; latched on accepted start.
- busy_out  out  1  operation in progress.
- done_out  out  1  one-cycle pulse: result valid.
- S_out  out  W  sum; holds the last result.
- C_out  out  1  carry-out of the top nibble.
- ovf_out  out  1  two's-complement overflow.

## Operation
- States: IDLE, RUN.
- Registers:
  - latched A/B/C0.
  - nibble index idx, width clog2(NIBBLES+1).
  - slice regs s_q[3:0] and c_q.
  - result register.
- IDLE:
  - start_in=1 at a rising edge latches A_in/B_in/C0_in.
  - Sets idx=0, busy_out=1, goes to RUN.
  - start_in=0: no change.
- RUN:
  - Slice inputs: a = A_lat[4*idx+3:4*idx], b = B_lat[4*idx+3:4*idx].
  - Slice carry-in: C0_lat if idx==0, else c_q.
  - Each edge: s_q/c_q register the slice result for nibble idx, and idx increments.
  - At edges where idx ≥ 1 before the edge: s_q (nibble idx-1) is written into S_out[4*(idx-1)+3 : 4*(idx-1)].
  - At the edge where idx==NIBBLES before the edge:
    - The top nibble is written.
    - C_out ← c_q.
    - ovf_out ← (A_lat[W-1]==B_lat[W-1]) && (final S[W-1]!=A_lat[W-1]).
    - done_out ← 1, busy_out ← 0, state → IDLE.
- Arithmetic: {C_out,S_out} = A_lat + B_lat + C0_lat, modulo 2^(W+1). No truncation other than at W+1 bits.
- S_out, C_out and ovf_out are stable between done pulses. Partial updates of S_out during RUN are allowed.
- Consumers sample S_out, C_out and ovf_out only with done_out.
- start_in while busy_out=1 is ignored: no queuing, no error flag.
- Changes to A_in/B_in/C0_in after acceptance do not affect the operation in flight.
- NIBBLES=1 degenerates to: latch, one slice cycle, done.

## Timing
- Reset (async assert, any state):
  - state=IDLE, idx=0.
  - busy_out=0, done_out=0, S_out=0, C_out=0, ovf_out=0, s_q=0, c_q=0.
  - Any operation in flight is abandoned with no done pulse.
- Reset deasserts synchronously to clk; the first start is accepted at the first edge after deassertion.
- Edge E0: start accepted; busy_out=1 from E0.
- Edges E1..E(NIBBLES): the slice registers nibbles 0..NIBBLES-1.
- Edge E(NIBBLES+1):
  - Final result, C_out and ovf_out valid.
  - done_out=1 for exactly one cycle; busy_out=0.
- Latency: NIBBLES+1 cycles from the accepting edge to done. NIBBLES=4 gives 5 cycles.
- Throughput:
  - start_in held high continuously is accepted at E(NIBBLES+2), the edge after done.
  - This gives one operation per NIBBLES+2 cycles.
  - A start in the done cycle is accepted at the next edge.
- The carry chain is never combinational across nibbles. The only combinational path is slice inputs → slice registers within one cycle.

## Test plan
- NIBBLES=4; A=0x000A, B=0x0007, C0=1 → done 5 cycles after start; S=0x0012, C=0, ovf=0.
- A=0xA5A5, B=0x5A5A, C0=1 → S=0x0000, C=1, ovf=0; the carry ripples through all four nibbles.
- A=0x7FFF, B=0x0001, C0=0 → S=0x8000, C=0, ovf=1. Then A=0xFFFF, B=0xFFFF, C0=1 → S=0xFFFF, C=1, ovf=0.
- start_in held high throughout, changing operands every cycle:
  - Exactly one done per 6 cycles.
  - Each result matches the operands present at its accepting edge.
  - Starts during busy are ignored.
- Assert rst two cycles into an operation:
  - All outputs read 0 immediately, asynchronously.
  - No done pulse occurs.
  - A subsequent 0x1234+0x4321+0 yields 0x5555, C=0.
- Random regression of 1000 operations, NIBBLES=1, 4 and 8, against a reference model of A+B+C0 → bit-exact S, C and ovf; done pulses exactly once per accepted start.
